uart_tx: RTL and testbench

Serial transmitter for the UART: serialises a DBIT-wide parallel word onto the `tx` line as start bit, LSB-first data bits, optional parity bit and stop period. It shares the 16x-baud `s_tick` generator with `uart_rx` and is the transmit-side counterpart to it. Its `tx` output drives the pin directly, and its ready/done handshake faces the host or FIFO logic.

---
 rtl/uart_tx.sv | 168 ++++++++++++++++
 tb/tb_uart_tx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: UART serialiser (start, LSB-first data, optional parity, stop) paced by a 16x s_tick.
// Define UART_TX_PARITY_EN to insert a parity bit after the data; ODD_PARITY then selects its sense.
module uart_tx #(
    parameter int DBIT       = 8,
    parameter int S_TICK     = 16,
    parameter int SB_TICK    = 16,
    parameter int ODD_PARITY = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] tx_data,
    output logic            tx,
    output logic            tx_ready,
    output logic            tx_done
);
    localparam int MAXT = (S_TICK > SB_TICK) ? S_TICK : SB_TICK;
    localparam int SW   = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [SW-1:0] S_LAST  = SW'(S_TICK - 1);
    localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

    if (ODD_PARITY != 0 && ODD_PARITY != 1) begin : g_bad_odd
        $error("uart_tx: ODD_PARITY must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          r_state, w_state;
    logic [SW-1:0]   r_s, w_s;
    logic [NW-1:0]   r_n, w_n;
    logic [DBIT-1:0] r_b, w_b;
    logic            r_tx, w_tx;
    logic            r_done, w_done;
`ifdef UART_TX_PARITY_EN
    logic            r_par, w_par;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_s     <= w_s;
            r_n     <= w_n;
            r_b     <= w_b;
            r_tx    <= w_tx;
            r_done  <= w_done;
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par;
`endif
        end
    end

    always_comb begin
        w_state = r_state;
        w_s     = r_s;
        w_n     = r_n;
        w_b     = r_b;
        w_tx    = r_tx;
        w_done  = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par   = r_par;
`endif
        case (r_state)
            IDLE: begin
                w_tx = 1'b1;
                if (tx_start) begin
                    w_b     = tx_data;
                    w_s     = '0;
                    w_tx    = 1'b0;
                    w_state = START;
`ifdef UART_TX_PARITY_EN
                    w_par   = 1'(ODD_PARITY);
`endif
                end
            end
            START: begin
                if (s_tick) begin
                    if (r_s == S_LAST) begin
                        w_s     = '0;
                        w_n     = '0;
                        w_tx    = r_b[0];
                        w_state = DATA;
                    end else begin
                        w_s = r_s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (r_s == S_LAST) begin
                        w_s = '0;
                        w_b = r_b >> 1;
`ifdef UART_TX_PARITY_EN
                        w_par = r_par ^ r_b[0];
`endif
                        if (r_n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            w_tx    = r_par ^ r_b[0];
                            w_state = PARITY;
`else
                            w_tx    = 1'b1;
                            w_state = STOP;
`endif
                        end else begin
                            w_n  = r_n + NW'(1);
                            w_tx = w_b[0];
                        end
                    end else begin
                        w_s = r_s + SW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (r_s == S_LAST) begin
                        w_s     = '0;
                        w_tx    = 1'b1;
                        w_state = STOP;
                    end else begin
                        w_s = r_s + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                w_tx = 1'b1;
                if (s_tick) begin
                    if (r_s == SB_LAST) begin
                        w_s     = '0;
                        w_done  = 1'b1;
                        w_state = IDLE;
                    end else begin
                        w_s = r_s + SW'(1);
                    end
                end
            end
            default: begin
                w_state = IDLE;
                w_tx    = 1'b1;
            end
        endcase
    end

    assign tx       = r_tx;
    assign tx_done  = r_done;
    assign tx_ready = (r_state == IDLE);
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomised-tick checks of uart_tx frames against a bit-list/tick-count model.
// Two instances: SB_TICK=16 (dut_a) and SB_TICK=32 (dut_b); honours UART_TX_PARITY_EN.
module tb_uart_tx;
    localparam int ST     = 16;
    localparam int TB_ODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic s_tick = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic [7:0] data_a = '0;
    logic [7:0] data_b = '0;
    logic tx_a, rdy_a, done_a, tx_b, rdy_b, done_b;
    int n_chk = 0;
    int n_fail = 0;
    int e_tx, e_hs;
    bit fin;

    uart_tx #(.DBIT(8), .S_TICK(ST), .SB_TICK(16), .ODD_PARITY(TB_ODD)) dut_a (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(start_a), .tx_data(data_a),
        .tx(tx_a), .tx_ready(rdy_a), .tx_done(done_a)
    );
    uart_tx #(.DBIT(8), .S_TICK(ST), .SB_TICK(32), .ODD_PARITY(TB_ODD)) dut_b (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(start_b), .tx_data(data_b),
        .tx(tx_b), .tx_ready(rdy_b), .tx_done(done_b)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1 s_tick = ($urandom_range(0, 2) == 0);
    end

    // Waits for tx_ready, returns just after the accepting edge.
    task automatic accept(input bit ls, input logic [7:0] d, input bit hold, output bit ok);
        ok = 1'b0;
        @(posedge clk);
        #1;
        if (ls) begin start_b = 1'b1; data_b = d; end
        else begin start_a = 1'b1; data_a = d; end
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            ok = ls ? rdy_b : rdy_a;
        end
        @(posedge clk);
        #1;
        if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
    endtask

    // Expected line: list of (level, tick duration); each level lasts exactly that many sampled ticks.
    task automatic check_frame(input bit ls, input logic [7:0] d, input int poke);
        logic bits [0:10];
        int dur [0:10];
        int nb, idx, cnt;
        logic exp_tx, otx, ordy, odone;
        nb = 0;
        bits[nb] = 1'b0; dur[nb] = ST; nb++;
        for (int i = 0; i < 8; i++) begin bits[nb] = d[i]; dur[nb] = ST; nb++; end
        bits[nb] = (^d) ^ (TB_ODD != 0); dur[nb] = ST; nb += PB;
        bits[nb] = 1'b1; dur[nb] = ls ? 32 : 16; nb++;
        e_tx = 0; e_hs = 0; fin = 1'b0; idx = 0; cnt = 0;
        for (int c = 0; c < 6000 && !fin; c++) begin
            @(negedge clk);
            otx   = ls ? tx_b : tx_a;
            ordy  = ls ? rdy_b : rdy_a;
            odone = ls ? done_b : done_a;
            exp_tx = (idx < nb) ? bits[idx] : 1'b1;
            if (otx !== exp_tx) e_tx++;
            if (ordy !== (idx == nb)) e_hs++;
            if (odone !== (idx == nb)) e_hs++;
            if (idx == nb) fin = 1'b1;
            else if (s_tick) begin
                cnt++;
                if (cnt == dur[idx]) begin idx++; cnt = 0; end
            end
            if (poke >= 0 && c == poke) begin start_a = 1'b1; data_a = 8'hFF; end
            if (poke >= 0 && c == poke + 1) begin start_a = 1'b0; data_a = d; end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx_a); end
        n_chk++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", rdy_a); end
        n_chk++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_a); end
        n_chk++; if (tx_b !== 1'b1) begin n_fail++; $display("FAIL reset_tx_b: got %b want 1", tx_b); end
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        n_chk++; if ({tx_a, rdy_a, done_a} !== 3'b110) begin n_fail++; $display("FAIL idle_after_reset: got %b want 110", {tx_a, rdy_a, done_a}); end
    endtask

    task automatic test_basic();
        bit ok;
        accept(1'b0, 8'hA5, 1'b0, ok);
        data_a = 8'h5A;
        check_frame(1'b0, 8'hA5, -1);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL basic_accept: got 0 want 1"); end
        n_chk++; if (e_tx !== 0) begin n_fail++; $display("FAIL basic_tx: %0d bad cycles want 0", e_tx); end
        n_chk++; if (e_hs !== 0) begin n_fail++; $display("FAIL basic_handshake: %0d bad cycles want 0", e_hs); end
        n_chk++; if (!fin) begin n_fail++; $display("FAIL basic_done: no tx_done, want one"); end
    endtask

    task automatic test_random();
        bit ok;
        logic [7:0] d;
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            accept(1'b0, d, 1'b0, ok);
            data_a = 8'($urandom);
            check_frame(1'b0, d, -1);
            n_chk++; if (!ok || !fin || e_tx != 0 || e_hs != 0) begin n_fail++; $display("FAIL random_%0h: ok=%0b fin=%0b tx_err=%0d hs_err=%0d want 1 1 0 0", d, ok, fin, e_tx, e_hs); end
        end
    endtask

    task automatic test_busy();
        bit ok;
        int bad;
        accept(1'b0, 8'h3C, 1'b0, ok);
        check_frame(1'b0, 8'h3C, 150);
        n_chk++; if (!ok || !fin) begin n_fail++; $display("FAIL busy_frame: ok=%0b fin=%0b want 1 1", ok, fin); end
        n_chk++; if (e_tx !== 0) begin n_fail++; $display("FAIL busy_tx: %0d bad cycles want 0", e_tx); end
        n_chk++; if (e_hs !== 0) begin n_fail++; $display("FAIL busy_handshake: %0d bad cycles want 0", e_hs); end
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if ({tx_a, rdy_a, done_a} !== 3'b110) bad++;
        end
        n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL busy_idle: %0d non-idle cycles want 0", bad); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        accept(1'b0, 8'h01, 1'b1, ok);
        data_a = 8'h80;
        check_frame(1'b0, 8'h01, -1);
        n_chk++; if (!ok || !fin || e_tx != 0 || e_hs != 0) begin n_fail++; $display("FAIL b2b_first: ok=%0b fin=%0b tx_err=%0d hs_err=%0d want 1 1 0 0", ok, fin, e_tx, e_hs); end
        @(posedge clk);
        #1 start_a = 1'b0;
        check_frame(1'b0, 8'h80, -1);
        n_chk++; if (e_tx !== 0) begin n_fail++; $display("FAIL b2b_second_tx: %0d bad cycles want 0", e_tx); end
        n_chk++; if (!fin || e_hs != 0) begin n_fail++; $display("FAIL b2b_second_hs: fin=%0b hs_err=%0d want 1 0", fin, e_hs); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cnt;
        accept(1'b0, 8'hC3, 1'b0, ok);
        cnt = 0;
        for (int c = 0; c < 3000 && cnt < 70; c++) begin
            @(negedge clk);
            if (s_tick) cnt++;
        end
        n_chk++; if (tx_a !== 1'b0) begin n_fail++; $display("FAIL mid_bit3: got %b want 0", tx_a); end
        #2 reset_n = 1'b0;
        #1;
        n_chk++; if ({tx_a, rdy_a, done_a} !== 3'b110) begin n_fail++; $display("FAIL mid_reset_async: got %b want 110", {tx_a, rdy_a, done_a}); end
        @(negedge clk);
        reset_n = 1'b1;
        accept(1'b0, 8'h55, 1'b0, ok);
        check_frame(1'b0, 8'h55, -1);
        n_chk++; if (!ok || !fin || e_tx != 0 || e_hs != 0) begin n_fail++; $display("FAIL mid_after: ok=%0b fin=%0b tx_err=%0d hs_err=%0d want 1 1 0 0", ok, fin, e_tx, e_hs); end
    endtask

    task automatic test_long_stop();
        bit ok;
        accept(1'b1, 8'h00, 1'b0, ok);
        check_frame(1'b1, 8'h00, -1);
        n_chk++; if (!ok || !fin) begin n_fail++; $display("FAIL long_frame: ok=%0b fin=%0b want 1 1", ok, fin); end
        n_chk++; if (e_tx !== 0) begin n_fail++; $display("FAIL long_tx: %0d bad cycles want 0", e_tx); end
        n_chk++; if (e_hs !== 0) begin n_fail++; $display("FAIL long_handshake: %0d bad cycles want 0", e_hs); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        test_long_stop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
